// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: packs 3 received bytes per word, writes
// consecutive addresses from 0 and keeps the core in reset until the load completes.
module imem_loader #(
  parameter int unsigned DATA_WIDTH    = 20,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned MEM_SIZE      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_wdata,
  output logic                     core_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned CNT_W = ADDRESS_WIDTH + 1;
  localparam int unsigned HI_W  = DATA_WIDTH - 16;
  localparam logic [CNT_W-1:0] MEM_CNT  = CNT_W'(MEM_SIZE);
  // Byte-2 bits that fall above the word; any 1 here flags err.
  localparam logic [7:0]       PAD_MASK = 8'(8'hFF << HI_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               byte_idx_q, byte_idx_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         total_q, total_d;
  logic [15:0]              asm_q, asm_d;
  logic                     err_q, err_d;
  logic                     rx_ready_q, rx_ready_d;
  logic                     imem_we_q, imem_we_d;
  logic [ADDRESS_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0]    imem_wdata_q, imem_wdata_d;
  logic                     core_hold_q, core_hold_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     byte_fire_c;
  logic [CNT_W-1:0]         count_clamped_c;
  logic [CNT_W-1:0]         cnt_inc_c;

  assign byte_fire_c     = rx_valid & rx_ready_q;
  assign count_clamped_c = (word_count > MEM_CNT) ? MEM_CNT : word_count;
  assign cnt_inc_c       = cnt_q + CNT_W'(1);

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      total_q      <= '0;
      asm_q        <= '0;
      err_q        <= 1'b0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      asm_q        <= asm_d;
      err_q        <= err_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic; status outputs are decoded from the next state so they are registered
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    total_d      = total_q;
    asm_d        = asm_q;
    err_d        = err_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          total_d    = count_clamped_c;
          addr_d     = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
          byte_idx_d = '0;
          asm_d      = '0;
          state_d    = (count_clamped_c == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (byte_fire_c) begin
          unique case (byte_idx_q)
            2'd0: begin
              asm_d[7:0] = rx_data;
              byte_idx_d = 2'd1;
            end
            2'd1: begin
              asm_d[15:8] = rx_data;
              byte_idx_d  = 2'd2;
            end
            default: begin
              if ((rx_data & PAD_MASK) != 8'h00) begin
                err_d = 1'b1;
              end
              imem_addr_d  = addr_q;
              imem_wdata_d = {rx_data[HI_W-1:0], asm_q};
              byte_idx_d   = '0;
              state_d      = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDRESS_WIDTH'(1);
        cnt_d   = cnt_inc_c;
        state_d = (cnt_inc_c == total_q) ? S_DONE : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d  = (state_d == S_RECV);
    imem_we_d   = (state_d == S_WRITE);
    busy_d      = (state_d == S_RECV) || (state_d == S_WRITE);
    core_hold_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-scenario tasks with hand-computed expected words.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [19:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  int n_vec;
  int n_err;

  logic [7:0]  wa[$];
  logic [19:0] wd[$];

  imem_loader #(
    .DATA_WIDTH(20),
    .ADDRESS_WIDTH(8),
    .MEM_SIZE(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word_count(word_count),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_hold(core_hold),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int wc);
    start      = 1'b1;
    word_count = 9'(wc);
    cyc();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t        = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && t < 50) begin
      cyc();
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL send_byte_timeout byte=%h rx_ready=%b required 1", b, rx_ready);
    end else begin
      cyc();
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    n_vec++; if (rx_ready !== 1'b0)   begin n_err++; $display("FAIL rst_rx_ready got %b want 0", rx_ready); end
    n_vec++; if (imem_we !== 1'b0)    begin n_err++; $display("FAIL rst_imem_we got %b want 0", imem_we); end
    n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_imem_addr got %h want 00", imem_addr); end
    n_vec++; if (imem_wdata !== 20'h0) begin n_err++; $display("FAIL rst_imem_wdata got %h want 0", imem_wdata); end
    n_vec++; if (core_hold !== 1'b1)  begin n_err++; $display("FAIL rst_core_hold got %b want 1", core_hold); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)       begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_vec++; if (err !== 1'b0)        begin n_err++; $display("FAIL rst_err got %b want 0", err); end
    rst = 1'b1;
    cyc();
    n_vec++; if (core_hold !== 1'b1 || rx_ready !== 1'b0) begin
      n_err++; $display("FAIL idle_after_rst core_hold=%b rx_ready=%b want 1/0", core_hold, rx_ready);
    end
  endtask

  task automatic test_two_word();
    int n0;
    n0 = wd.size();
    do_start(2);
    n_vec++; if (rx_ready !== 1'b1 || busy !== 1'b1 || core_hold !== 1'b1) begin
      n_err++; $display("FAIL two_recv rx_ready=%b busy=%b hold=%b want 1/1/1", rx_ready, busy, core_hold);
    end
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h05);
    n_vec++; if (imem_we !== 1'b1)        begin n_err++; $display("FAIL two_w0_we got %b want 1", imem_we); end
    n_vec++; if (imem_addr !== 8'h00)     begin n_err++; $display("FAIL two_w0_addr got %h want 00", imem_addr); end
    n_vec++; if (imem_wdata !== 20'h51234) begin n_err++; $display("FAIL two_w0_data got %h want 51234", imem_wdata); end
    n_vec++; if (rx_ready !== 1'b0)       begin n_err++; $display("FAIL two_w0_ready got %b want 0", rx_ready); end
    cyc();
    n_vec++; if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 20'h51234) begin
      n_err++; $display("FAIL two_hold we=%b addr=%h data=%h want 0/00/51234", imem_we, imem_addr, imem_wdata);
    end
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h0F);
    n_vec++; if (imem_we !== 1'b1 || imem_addr !== 8'h01 || imem_wdata !== 20'hFFFFF) begin
      n_err++; $display("FAIL two_w1 we=%b addr=%h data=%h want 1/01/fffff", imem_we, imem_addr, imem_wdata);
    end
    n_vec++; if (done !== 1'b0 || core_hold !== 1'b1) begin
      n_err++; $display("FAIL two_w1_status done=%b hold=%b want 0/1", done, core_hold);
    end
    cyc();
    n_vec++; if (done !== 1'b1 || core_hold !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL two_done done=%b hold=%b err=%b busy=%b want 1/0/0/0", done, core_hold, err, busy);
    end
    n_vec++; if (wd.size() !== n0 + 2) begin
      n_err++; $display("FAIL two_write_count got %0d want %0d", wd.size() - n0, 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [9];
    logic [19:0] exp_w [3];
    int n0;
    do_start(2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    n_vec++; if (rx_ready !== 1'b0 || imem_we !== 1'b1 || imem_wdata !== 20'h32211) begin
      n_err++; $display("FAIL bp_write rdy=%b we=%b data=%h want 0/1/32211", rx_ready, imem_we, imem_wdata);
    end
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h06);
    n_vec++; if (imem_we !== 1'b1 || imem_addr !== 8'h01 || imem_wdata !== 20'h65544) begin
      n_err++; $display("FAIL bp_w1 we=%b addr=%h data=%h want 1/01/65544", imem_we, imem_addr, imem_wdata);
    end
    cyc();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_done got %b want 1", done); end

    bytes = '{8'h01, 8'h02, 8'h03, 8'hA0, 8'hB0, 8'h0C, 8'hFF, 8'h00, 8'h0E};
    exp_w = '{20'h30201, 20'hCB0A0, 20'hE00FF};
    n0 = wd.size();
    do_start(3);
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 3)) cyc();
      send_byte(bytes[i]);
    end
    repeat (2) cyc();
    n_vec++; if (wd.size() !== n0 + 3) begin
      n_err++; $display("FAIL gap_count got %0d want 3", wd.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (wa[n0+i] !== 8'(i) || wd[n0+i] !== exp_w[i]) begin
          n_err++; $display("FAIL gap_word%0d addr=%h data=%h want %h/%h", i, wa[n0+i], wd[n0+i], 8'(i), exp_w[i]);
        end
      end
    end
    n_vec++; if (done !== 1'b1 || err !== 1'b0) begin
      n_err++; $display("FAIL gap_done done=%b err=%b want 1/0", done, err);
    end
  endtask

  task automatic test_pad_error();
    do_start(1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hA7);
    n_vec++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 20'h70000) begin
      n_err++; $display("FAIL pad_write we=%b addr=%h data=%h want 1/00/70000", imem_we, imem_addr, imem_wdata);
    end
    cyc();
    n_vec++; if (err !== 1'b1 || done !== 1'b1) begin
      n_err++; $display("FAIL pad_status err=%b done=%b want 1/1", err, done);
    end
  endtask

  task automatic test_zero_count();
    int n0;
    n0 = wd.size();
    do_start(0);
    n_vec++; if (done !== 1'b1 || busy !== 1'b0 || core_hold !== 1'b0 || rx_ready !== 1'b0) begin
      n_err++; $display("FAIL zero_done done=%b busy=%b hold=%b rdy=%b want 1/0/0/0", done, busy, core_hold, rx_ready);
    end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL zero_err_cleared got %b want 0", err); end
    repeat (3) cyc();
    n_vec++; if (wd.size() !== n0) begin
      n_err++; $display("FAIL zero_writes got %0d want 0", wd.size() - n0);
    end
  endtask

  task automatic test_full_load();
    int n0;
    int bad;
    logic [7:0]  lo;
    logic [19:0] ew;
    n0 = wd.size();
    do_start(300);
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i);
      if (i == 100) begin
        start      = 1'b1;
        word_count = 9'd1;
        cyc();
        start      = 1'b0;
      end
      send_byte(lo); send_byte(~lo); send_byte({4'h0, lo[3:0]});
    end
    n_vec++; if (imem_we !== 1'b1 || imem_addr !== 8'hFF || imem_wdata !== 20'hF00FF) begin
      n_err++; $display("FAIL full_last we=%b addr=%h data=%h want 1/ff/f00ff", imem_we, imem_addr, imem_wdata);
    end
    cyc();
    n_vec++; if (done !== 1'b1 || core_hold !== 1'b0) begin
      n_err++; $display("FAIL full_done done=%b hold=%b want 1/0", done, core_hold);
    end
    repeat (2) cyc();
    n_vec++; if (wd.size() !== n0 + 256) begin
      n_err++; $display("FAIL full_count got %0d want 256", wd.size() - n0);
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        lo = 8'(i);
        ew = {lo[3:0], ~lo, lo};
        if (wa[n0+i] !== lo || wd[n0+i] !== ew) bad++;
      end
      n_vec++; if (bad !== 0) begin
        n_err++; $display("FAIL full_contents bad_words=%0d want 0", bad);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int n0;
    do_start(2);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h05);
    send_byte(8'hAA); send_byte(8'hBB);
    n0 = wd.size();
    rst = 1'b0;
    #1;
    n_vec++; if (core_hold !== 1'b1 || imem_addr !== 8'h00 || imem_we !== 1'b0) begin
      n_err++; $display("FAIL mid_rst hold=%b addr=%h we=%b want 1/00/0", core_hold, imem_addr, imem_we);
    end
    n_vec++; if (busy !== 1'b0 || rx_ready !== 1'b0 || done !== 1'b0 || imem_wdata !== 20'h0) begin
      n_err++; $display("FAIL mid_rst_out busy=%b rdy=%b done=%b data=%h want 0/0/0/0", busy, rx_ready, done, imem_wdata);
    end
    cyc();
    rst = 1'b1;
    repeat (2) cyc();
    n_vec++; if (wd.size() !== n0) begin
      n_err++; $display("FAIL mid_no_write got %0d want 0", wd.size() - n0);
    end
    do_start(1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h04);
    n_vec++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 20'h45678) begin
      n_err++; $display("FAIL mid_reload we=%b addr=%h data=%h want 1/00/45678", imem_we, imem_addr, imem_wdata);
    end
    cyc();
    n_vec++; if (done !== 1'b1 || core_hold !== 1'b0) begin
      n_err++; $display("FAIL mid_reload_done done=%b hold=%b want 1/0", done, core_hold);
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b0;
    start      = 1'b0;
    word_count = '0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    n_vec      = 0;
    n_err      = 0;
    test_reset();
    test_two_word();
    test_back_to_back();
    test_pad_error();
    test_zero_count();
    test_full_load();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that writes the instruction memory read by the unicycle core.
- Accepts bytes over a valid/ready handshake and packs 3 bytes into one DATA_WIDTH instruction word.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the core in reset until the requested word count has been written.

Parameters:
- DATA_WIDTH, 20, instruction word width; at most 24, so 3 bytes cover one word.
- ADDRESS_WIDTH, 8, instruction memory address width.
- MEM_SIZE, 256, number of instruction memory words.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle request to begin a load session.
- word_count  in  ADDRESS_WIDTH+1  number of words to load; sampled when start is accepted.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDRESS_WIDTH  write address.
- imem_wdata  out  DATA_WIDTH  write data.
- core_hold  out  1  1 = core must be held in reset.
- busy  out  1  load session in progress.
- done  out  1  sticky; last session completed.
- err  out  1  sticky; a session received a nonzero pad bit.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, byte index=0, address=0, word counter=0, assembly register=0.
  - Output reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, busy=0, done=0, err=0.
- A byte transfer occurs only on a rising edge where rx_valid=1 and rx_ready=1.
- States:
  - IDLE: rx_ready=0, core_hold=1.
    - start=1 latches min(word_count, MEM_SIZE), clears address, done and err.
    - Goes to RECV, or to DONE if the latched count is 0.
  - RECV: rx_ready=1, busy=1.
    - Byte 0 -> word bits [7:0].
    - Byte 1 -> word bits [15:8].
    - Byte 2 -> bits [DATA_WIDTH-1:16]. Bits of byte 2 above DATA_WIDTH-16 are pad bits; if any pad bit is 1, err is set.
    - After byte 2 is accepted, go to WRITE.
  - WRITE: exactly one cycle, busy=1.
    - imem_we=1; imem_addr = current address; imem_wdata = assembled word.
    - rx_ready=0, so no byte is accepted in this cycle.
    - Next cycle: address+1 and words_written+1.
    - Go to DONE if words_written reaches the latched count, otherwise return to RECV with byte index=0.
  - DONE: done=1, core_hold=0, busy=0, rx_ready=0.
    - start=1 behaves as in IDLE: core_hold returns to 1 and done clears in the same transition.
- Latency: imem_we is asserted in the cycle immediately after the edge that accepts byte 2.
- core_hold falls in the cycle after the final WRITE cycle.
- start is ignored while busy=1.
- imem_we is 0 in every state except WRITE.
- imem_addr and imem_wdata hold their last value outside WRITE.
- Address wrap: the latched count is clamped to MEM_SIZE, so the address never exceeds MEM_SIZE-1. The last write of a full load goes to address MEM_SIZE-1.
- Gaps: rx_valid may drop at any point. Partial-word state is held indefinitely with no timeout.
- Mid-session reset: partial word discarded, no write issued, all outputs return to reset values (core_hold=1).
- A pad error does not block the write: the word is still written with pad bits dropped.

Test Plan:
- Reset values: hold rst=0, then release -> rx_ready=0, imem_we=0, core_hold=1, busy=0, done=0, err=0.
- Two-word load: start with word_count=2, bytes 34 12 05 FF FF 0F.
  - Required writes: addr 0 = 0x51234, then addr 1 = 0xFFFFF, each a one-cycle imem_we one cycle after its third byte.
  - Then done=1 and core_hold=0 on the following cycle; err=0.
- Backpressure: rx_valid held 1 across the WRITE cycle.
  - rx_ready=0 in that cycle and the byte on rx_data is not consumed; it becomes byte 0 of the next word.
  - Random rx_valid gaps produce identical memory contents.
- Pad error: word_count=1, bytes 00 00 A7 -> addr 0 = 0x70000 written, err=1, done=1.
- Boundaries:
  - word_count=0 -> DONE the cycle after start, with no imem_we.
  - word_count=300 -> exactly 256 writes, last at addr 0xFF, then done=1.
  - start while busy has no effect.
- Reset mid-word: after 2 bytes of word 1, pulse rst=0.
  - Required: no write for that word, core_hold=1, address=0.
  - A new start with word_count=1 writes addr 0 correctly.
